reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 123 ++++++++++++
 tb/tb_reg_file_mp.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports (B wins on collision), two registered
// read ports with optional write-to-read forwarding, and a per-register pending scoreboard.
module reg_file_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we_a,
    input  logic                    we_b,
    input  logic [ADDR_W-1:0]       waddr_a,
    input  logic [ADDR_W-1:0]       waddr_b,
    input  logic [DATA_W-1:0]       wdata_a,
    input  logic [DATA_W-1:0]       wdata_b,
    input  logic                    re_1,
    input  logic                    re_2,
    input  logic [ADDR_W-1:0]       raddr_1,
    input  logic [ADDR_W-1:0]       raddr_2,
    output logic [DATA_W-1:0]       rdata_1,
    output logic [DATA_W-1:0]       rdata_2,
    output logic                    rvalid_1,
    output logic                    rvalid_2,
    output logic                    rbusy_1,
    output logic                    rbusy_2,
    input  logic                    reserve_en,
    input  logic [ADDR_W-1:0]       reserve_addr,
    output logic [(2**ADDR_W)-1:0]  pending
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   pending_q, pending_d;
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_d [2];
    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        rbusy_q, rbusy_d;

    logic [1:0]        re;
    logic [ADDR_W-1:0] raddr [2];
    logic              we_a_eff, we_b_eff, reserve_eff;
    logic              hit_a, hit_b;

    assign re       = {re_2, re_1};
    assign raddr[0] = raddr_1;
    assign raddr[1] = raddr_2;

    // With a hardwired zero register, anything aimed at address 0 is dropped up front.
    always_comb begin
        we_a_eff    = we_a && !(ZERO_REG != 0 && waddr_a == '0);
        we_b_eff    = we_b && !(ZERO_REG != 0 && waddr_b == '0);
        reserve_eff = reserve_en && !(ZERO_REG != 0 && reserve_addr == '0);
    end

    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        if (we_a_eff) begin
            regs_d[waddr_a]    = wdata_a;
            pending_d[waddr_a] = 1'b0;
        end
        if (we_b_eff) begin
            regs_d[waddr_b]    = wdata_b;
            pending_d[waddr_b] = 1'b0;
        end
        // A reservation landing with a write to the same register keeps it pending.
        if (reserve_eff) begin
            pending_d[reserve_addr] = 1'b1;
        end
    end

    always_comb begin
        rdata_d  = rdata_q;
        rbusy_d  = rbusy_q;
        rvalid_d = re;
        hit_a    = 1'b0;
        hit_b    = 1'b0;
        for (int p = 0; p < 2; p++) begin
            hit_a = (BYPASS != 0) && we_a_eff && (waddr_a == raddr[p]);
            hit_b = (BYPASS != 0) && we_b_eff && (waddr_b == raddr[p]);
            if (re[p]) begin
                if (hit_b) begin
                    rdata_d[p] = wdata_b;
                end else if (hit_a) begin
                    rdata_d[p] = wdata_a;
                end else if (ZERO_REG != 0 && raddr[p] == '0) begin
                    rdata_d[p] = '0;
                end else begin
                    rdata_d[p] = regs_q[raddr[p]];
                end
                rbusy_d[p] = pending_q[raddr[p]] && !(hit_a || hit_b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q    <= '{default: '0};
            pending_q <= '0;
            rdata_q   <= '{default: '0};
            rvalid_q  <= '0;
            rbusy_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            rbusy_q   <= rbusy_d;
        end
    end

    assign rdata_1  = rdata_q[0];
    assign rdata_2  = rdata_q[1];
    assign rvalid_1 = rvalid_q[0];
    assign rvalid_2 = rvalid_q[1];
    assign rbusy_1  = rbusy_q[0];
    assign rbusy_2  = rbusy_q[1];
    assign pending  = pending_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default, no-bypass and zero-register instances
// share one stimulus bus; a vector table plus short hand-written sequences.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        we_a, we_b, re_1, re_2, reserve_en;
    logic [2:0]  waddr_a, waddr_b, raddr_1, raddr_2, reserve_addr;
    logic [15:0] wdata_a, wdata_b;

    logic [15:0] rdata_1, rdata_2, rdata_1_nb, rdata_2_nb, rdata_1_z, rdata_2_z;
    logic        rvalid_1, rvalid_2, rvalid_1_nb, rvalid_2_nb, rvalid_1_z, rvalid_2_z;
    logic        rbusy_1, rbusy_2, rbusy_1_nb, rbusy_2_nb, rbusy_1_z, rbusy_2_z;
    logic [7:0]  pending, pending_nb, pending_z;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_file_mp dut (
        .clk(clk), .reset(reset),
        .we_a(we_a), .we_b(we_b), .waddr_a(waddr_a), .waddr_b(waddr_b),
        .wdata_a(wdata_a), .wdata_b(wdata_b),
        .re_1(re_1), .re_2(re_2), .raddr_1(raddr_1), .raddr_2(raddr_2),
        .rdata_1(rdata_1), .rdata_2(rdata_2), .rvalid_1(rvalid_1), .rvalid_2(rvalid_2),
        .rbusy_1(rbusy_1), .rbusy_2(rbusy_2),
        .reserve_en(reserve_en), .reserve_addr(reserve_addr), .pending(pending)
    );

    reg_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .we_a(we_a), .we_b(we_b), .waddr_a(waddr_a), .waddr_b(waddr_b),
        .wdata_a(wdata_a), .wdata_b(wdata_b),
        .re_1(re_1), .re_2(re_2), .raddr_1(raddr_1), .raddr_2(raddr_2),
        .rdata_1(rdata_1_nb), .rdata_2(rdata_2_nb), .rvalid_1(rvalid_1_nb), .rvalid_2(rvalid_2_nb),
        .rbusy_1(rbusy_1_nb), .rbusy_2(rbusy_2_nb),
        .reserve_en(reserve_en), .reserve_addr(reserve_addr), .pending(pending_nb)
    );

    reg_file_mp #(.ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset),
        .we_a(we_a), .we_b(we_b), .waddr_a(waddr_a), .waddr_b(waddr_b),
        .wdata_a(wdata_a), .wdata_b(wdata_b),
        .re_1(re_1), .re_2(re_2), .raddr_1(raddr_1), .raddr_2(raddr_2),
        .rdata_1(rdata_1_z), .rdata_2(rdata_2_z), .rvalid_1(rvalid_1_z), .rvalid_2(rvalid_2_z),
        .rbusy_1(rbusy_1_z), .rbusy_2(rbusy_2_z),
        .reserve_en(reserve_en), .reserve_addr(reserve_addr), .pending(pending_z)
    );

    typedef struct {
        logic        rst;
        logic        we_a;
        logic [2:0]  wa_a;
        logic [15:0] wd_a;
        logic        we_b;
        logic [2:0]  wa_b;
        logic [15:0] wd_b;
        logic        re1;
        logic [2:0]  ra1;
        logic        re2;
        logic [2:0]  ra2;
        logic        rsv;
        logic [2:0]  rsa;
        logic [15:0] e_rd1;
        logic        e_rv1;
        logic        e_rb1;
        logic [15:0] e_rd2;
        logic        e_rv2;
        logic        e_rb2;
        logic [7:0]  e_pend;
    } vec_t;

    vec_t vt [15];

    function automatic vec_t mk(int rst, int wea, int waa, int wda, int web, int wab, int wdb,
                                int r1, int a1, int r2, int a2, int rsv, int rsa,
                                int rd1, int rv1, int rb1, int rd2, int rv2, int rb2, int pend);
        vec_t v;
        v.rst  = 1'(rst);
        v.we_a = 1'(wea);  v.wa_a = 3'(waa);  v.wd_a = 16'(wda);
        v.we_b = 1'(web);  v.wa_b = 3'(wab);  v.wd_b = 16'(wdb);
        v.re1  = 1'(r1);   v.ra1  = 3'(a1);
        v.re2  = 1'(r2);   v.ra2  = 3'(a2);
        v.rsv  = 1'(rsv);  v.rsa  = 3'(rsa);
        v.e_rd1 = 16'(rd1); v.e_rv1 = 1'(rv1); v.e_rb1 = 1'(rb1);
        v.e_rd2 = 16'(rd2); v.e_rv2 = 1'(rv2); v.e_rb2 = 1'(rb2);
        v.e_pend = 8'(pend);
        return v;
    endfunction

    task automatic idle();
        reset = 1'b0; we_a = 1'b0; we_b = 1'b0; re_1 = 1'b0; re_2 = 1'b0; reserve_en = 1'b0;
        waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0;
        raddr_1 = '0; raddr_2 = '0; reserve_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset = v.rst;
        we_a = v.we_a; waddr_a = v.wa_a; wdata_a = v.wd_a;
        we_b = v.we_b; waddr_b = v.wa_b; wdata_b = v.wd_b;
        re_1 = v.re1;  raddr_1 = v.ra1;
        re_2 = v.re2;  raddr_2 = v.ra2;
        reserve_en = v.rsv; reserve_addr = v.rsa;
    endtask

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    initial begin
        // inputs: rst | we_a addr data | we_b addr data | re1 a | re2 a | rsv a
        // expected: rd1 rv1 rb1 | rd2 rv2 rb2 | pending
        vt[0]  = mk(1, 0,0,0,       0,0,0,       0,0, 0,0, 0,0, 'h0000,0,0, 'h0000,0,0, 'h00);
        vt[1]  = mk(0, 1,3,'h1234,  0,0,0,       0,0, 0,0, 0,0, 'h0000,0,0, 'h0000,0,0, 'h00);
        vt[2]  = mk(0, 0,0,0,       0,0,0,       1,3, 0,0, 0,0, 'h1234,1,0, 'h0000,0,0, 'h00);
        vt[3]  = mk(0, 1,5,'hAAAA,  1,5,'h5555,  0,0, 1,5, 0,0, 'h1234,0,0, 'h5555,1,0, 'h00);
        vt[4]  = mk(0, 0,0,0,       0,0,0,       1,5, 1,3, 0,0, 'h5555,1,0, 'h1234,1,0, 'h00);
        vt[5]  = mk(0, 1,2,'hBEEF,  0,0,0,       1,2, 0,0, 0,0, 'hBEEF,1,0, 'h1234,0,0, 'h00);
        vt[6]  = mk(0, 0,0,0,       0,0,0,       0,0, 0,0, 1,4, 'hBEEF,0,0, 'h1234,0,0, 'h10);
        vt[7]  = mk(0, 0,0,0,       0,0,0,       1,4, 1,2, 0,0, 'h0000,1,1, 'hBEEF,1,0, 'h10);
        vt[8]  = mk(0, 1,4,'h0042,  0,0,0,       0,0, 1,4, 1,4, 'h0000,0,1, 'h0042,1,0, 'h10);
        vt[9]  = mk(0, 0,0,0,       0,0,0,       1,4, 0,0, 0,0, 'h0042,1,1, 'h0042,0,0, 'h10);
        vt[10] = mk(0, 0,0,0,       1,4,'h0043,  0,0, 0,0, 0,0, 'h0042,0,1, 'h0042,0,0, 'h00);
        vt[11] = mk(0, 0,0,0,       0,0,0,       1,4, 1,4, 0,0, 'h0043,1,0, 'h0043,1,0, 'h00);
        vt[12] = mk(0, 1,7,'hFFFF,  0,0,0,       0,0, 0,0, 1,1, 'h0043,0,0, 'h0043,0,0, 'h02);
        vt[13] = mk(1, 0,0,0,       1,6,'h1111,  1,7, 0,0, 1,6, 'h0000,0,0, 'h0000,0,0, 'h00);
        vt[14] = mk(0, 0,0,0,       0,0,0,       1,3, 1,7, 0,0, 'h0000,1,0, 'h0000,1,0, 'h00);

        idle();
        #2;
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vt[i]);
            tick();
            check_output($sformatf("v%0d rdata_1", i),  rdata_1,         vt[i].e_rd1);
            check_output($sformatf("v%0d rvalid_1", i), 16'(rvalid_1),   16'(vt[i].e_rv1));
            check_output($sformatf("v%0d rbusy_1", i),  16'(rbusy_1),    16'(vt[i].e_rb1));
            check_output($sformatf("v%0d rdata_2", i),  rdata_2,         vt[i].e_rd2);
            check_output($sformatf("v%0d rvalid_2", i), 16'(rvalid_2),   16'(vt[i].e_rv2));
            check_output($sformatf("v%0d rbusy_2", i),  16'(rbusy_2),    16'(vt[i].e_rb2));
            check_output($sformatf("v%0d pending", i),  16'(pending),    16'(vt[i].e_pend));
        end

        // No-bypass: same-cycle read sees the pre-edge value and the stale pending bit.
        idle(); reset = 1'b1; tick();
        idle(); we_a = 1'b1; waddr_a = 3'd2; wdata_a = 16'hBEEF; re_1 = 1'b1; raddr_1 = 3'd2; tick();
        check_output("byp rdata_1",    rdata_1,    16'hBEEF);
        check_output("nobyp rdata_1",  rdata_1_nb, 16'h0000);
        idle(); re_1 = 1'b1; raddr_1 = 3'd2; tick();
        check_output("nobyp reread",   rdata_1_nb, 16'hBEEF);
        idle(); reserve_en = 1'b1; reserve_addr = 3'd6; tick();
        idle(); we_a = 1'b1; waddr_a = 3'd6; wdata_a = 16'h0077; re_1 = 1'b1; raddr_1 = 3'd6; tick();
        check_output("byp fwd data",   rdata_1,    16'h0077);
        check_output("byp fwd busy",   16'(rbusy_1),    16'h0000);
        check_output("nobyp old data", rdata_1_nb, 16'h0000);
        check_output("nobyp busy",     16'(rbusy_1_nb), 16'h0001);
        check_output("nobyp pending",  16'(pending_nb), 16'h0000);

        // Zero register: writes and reservations to r0 have no effect.
        idle(); reset = 1'b1; tick();
        idle(); we_a = 1'b1; waddr_a = 3'd0; wdata_a = 16'hFFFF; reserve_en = 1'b1; reserve_addr = 3'd0; tick();
        check_output("zero pending",   16'(pending_z), 16'h0000);
        check_output("plain pending",  16'(pending),   16'h0001);
        idle(); we_b = 1'b1; waddr_b = 3'd0; wdata_b = 16'hFFFF; re_1 = 1'b1; raddr_1 = 3'd0; tick();
        check_output("zero rdata_1",   rdata_1_z,  16'h0000);
        check_output("zero rvalid_1",  16'(rvalid_1_z), 16'h0001);
        check_output("zero rbusy_1",   16'(rbusy_1_z),  16'h0000);
        check_output("plain r0 fwd",   rdata_1,    16'hFFFF);
        check_output("plain pend clr", 16'(pending),    16'h0000);
        idle(); re_2 = 1'b1; raddr_2 = 3'd0; tick();
        check_output("zero rdata_2",   rdata_2_z,  16'h0000);
        check_output("plain r0 read",  rdata_2,    16'hFFFF);
        idle(); reserve_en = 1'b1; reserve_addr = 3'd0; tick();
        idle(); re_1 = 1'b1; raddr_1 = 3'd0; tick();
        check_output("zero rbusy r0",  16'(rbusy_1_z), 16'h0000);
        check_output("plain rbusy r0", 16'(rbusy_1),   16'h0001);

        // Reset in the same edge as a read discards the result.
        idle(); we_a = 1'b1; waddr_a = 3'd1; wdata_a = 16'h1111; tick();
        idle(); reset = 1'b1; re_1 = 1'b1; raddr_1 = 3'd1; re_2 = 1'b1; raddr_2 = 3'd1; tick();
        check_output("rst rdata_1",    rdata_1,   16'h0000);
        check_output("rst rvalid_1",   16'(rvalid_1), 16'h0000);
        check_output("rst rvalid_2",   16'(rvalid_2), 16'h0000);
        check_output("rst pending",    16'(pending),  16'h0000);
        idle(); re_1 = 1'b1; raddr_1 = 3'd1; tick();
        check_output("post-rst rdata", rdata_1,   16'h0000);
        check_output("post-rst valid", 16'(rvalid_1), 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
